// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 by default, LSB first, idle-high, with a one-entry holding register.
// Defining UART_TX_PARITY_EN inserts a parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned STOP_W = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e               state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic                 hold_full_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [STOP_W-1:0]    stop_cnt_q;
  logic                 tx_serial_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic write_en;
  logic last_bit;
  logic last_stop;
  logic frame_end;
  logic load_en;
  logic unused_cfg;

  // Upper data_in bits are ignored for narrow frames; parity sense is unused without parity.
  assign unused_cfg = ^{PARITY_ODD, data_in};

  assign write_en  = tx_valid && tx_ready_q;
  assign last_bit  = (bit_idx_q == IDX_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == STOP_W'(STOP_BITS - 1));
  assign frame_end = baud_tick && (state_q == S_STOP) && last_stop;
  // A held byte launches on a tick from IDLE, or straight off the last stop bit.
  assign load_en   = baud_tick && hold_full_q && ((state_q == S_IDLE) || frame_end);

  // Write and load never coincide: a load needs a full register, a write an empty one.
  always_comb begin
    hold_full_d = hold_full_q;
    if (write_en) begin
      hold_full_d = 1'b1;
    end else if (load_en) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      hold_full_q <= hold_full_d;
      tx_ready_q  <= !hold_full_d;
      tx_done_q   <= frame_end;

      if (write_en) begin
        hold_q <= data_in[DATA_BITS-1:0];
      end

      if (load_en) begin
        shift_q     <= hold_q;
        tx_serial_q <= 1'b0;
        tx_busy_q   <= 1'b1;
        state_q     <= S_START;
`ifdef UART_TX_PARITY_EN
        parity_q    <= (^hold_q) ^ PARITY_ODD;
`endif
      end else if (baud_tick) begin
        case (state_q)
          S_START: begin
            tx_serial_q <= shift_q[0];
            bit_idx_q   <= '0;
            state_q     <= S_DATA;
          end
          S_DATA: begin
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              tx_serial_q <= parity_q;
              state_q     <= S_PARITY;
`else
              tx_serial_q <= 1'b1;
              stop_cnt_q  <= '0;
              state_q     <= S_STOP;
`endif
            end else begin
              shift_q     <= shift_q >> 1;
              tx_serial_q <= shift_q[1];
              bit_idx_q   <= bit_idx_q + IDX_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            tx_serial_q <= 1'b1;
            stop_cnt_q  <= '0;
            state_q     <= S_STOP;
          end
`endif
          S_STOP: begin
            tx_serial_q <= 1'b1;
            if (last_stop) begin
              tx_busy_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + STOP_W'(1);
            end
          end
          default: begin
            tx_serial_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

  // Handshake invariants: ready mirrors an empty holding register; done is a single-cycle pulse.
  a_ready_mirrors_hold: assert property (@(posedge clk) disable iff (rst) tx_ready_q == !hold_full_q);
  a_done_single:        assert property (@(posedge clk) disable iff (rst) tx_done_q |=> !tx_done_q);

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: expected bytes are queued on write and checked bit-by-bit
// (every clock of every bit) by a line monitor; STOP_BITS=2 and parity variants checked inline.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned BIT_CLKS = 16;
  localparam int unsigned NBITS    = 1 + 8 + PAR + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready, tx_serial, tx_busy, tx_done;

  logic [7:0] data2;
  logic       valid2;
  logic       ready2, serial2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int busy_falls = 0;
  int frames_seen = 0;
  int last_gap = 0;
  int idle_run = 0;
  int tick_cnt = 0;
  bit mon_busy = 1'b0;
  bit prev_busy = 1'b0;
  logic [7:0] q[$];
  logic [7:0] q2[$];

  uart_transmitter dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_transmitter #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data2), .tx_valid(valid2),
    .tx_ready(ready2), .tx_serial(serial2), .tx_busy(busy2), .tx_done(done2)
  );

`ifdef UART_TX_PARITY_EN
  logic [7:0] data3;
  logic       valid3;
  logic       ready3, serial3, busy3, done3;

  uart_transmitter #(.PARITY_ODD(1'b1)) dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data3), .tx_valid(valid3),
    .tx_ready(ready3), .tx_serial(serial3), .tx_busy(busy3), .tx_done(done3)
  );
`endif

  always #5 clk = ~clk;

  // One-clock tick every 16 clocks, driven away from the active edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt  = (tick_cnt + 1) % BIT_CLKS;
      baud_tick = (tick_cnt == 0);
    end
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (prev_busy && (tx_busy === 1'b0)) busy_falls++;
    prev_busy = (tx_busy === 1'b1);
  end

  // Expected line level for frame bit b (0 = start, then LSB-first data, parity, stop bits).
  function automatic logic frame_bit(input logic [7:0] d, input int b, input logic podd);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((PAR == 1) && (b == 9)) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic mon_frame();
    logic [7:0] exp;
    bit   have;
    bit   abort;
    int   bad;
    logic expb;
    logic got;
    mon_busy = 1'b1;
    abort    = 1'b0;
    exp      = 8'h00;
    have     = 1'b0;
    if (q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_frame: start bit seen with no byte queued");
    end else begin
      exp  = q.pop_front();
      have = 1'b1;
    end
    for (int b = 0; b < NBITS && !abort; b++) begin
      bad  = 0;
      got  = 1'b1;
      expb = frame_bit(exp, b, 1'b0);
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst === 1'b1) begin
          abort = 1'b1;
          break;
        end
        if (tx_serial !== expb) begin
          bad++;
          got = tx_serial;
        end
      end
      if (!abort && have) begin
        n_checks++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL frame_bit byte=%02h bit=%0d: line=%b on %0d of %0d clks, required %b",
                   exp, b, got, bad, BIT_CLKS, expb);
        end
      end
    end
    if (!abort) frames_seen++;
    mon_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        idle_run = 0;
      end else if (tx_serial === 1'b0) begin
        last_gap = idle_run;
        mon_frame();
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  task automatic do_write(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while ((tx_ready !== 1'b1) && (w < 2000)) begin
      @(negedge clk);
      w++;
    end
    if (tx_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL write_wait byte=%02h: tx_ready=%b after %0d clks, required 1", d, tx_ready, w);
      return;
    end
    data_in  = d;
    tx_valid = 1'b1;
    q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (((q.size() != 0) || mon_busy || (tx_busy !== 1'b0)) && (w < 3000));
    if (w >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b queued=%0d, required idle", tag, tx_busy, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b, required 1", tx_serial); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", tx_done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_55();
    int d0, f0, b0;
    d0 = done_cnt; f0 = frames_seen; b0 = busy_falls;
    do_write(8'h55);
    #1;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_write: got %b, required 0", tx_ready); end
    wait_idle("single");
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done_cycles: got %0d, required 1", done_cnt - d0); end
    n_checks++; if (frames_seen - f0 != 1) begin n_fail++; $display("FAIL single_frames: got %0d, required 1", frames_seen - f0); end
    n_checks++; if (busy_falls - b0 != 1) begin n_fail++; $display("FAIL single_busy_periods: got %0d, required 1", busy_falls - b0); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, required 0", tx_busy); end
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL single_idle_line: got %b, required 1", tx_serial); end
  endtask

  task automatic test_back_to_back();
    int d0, f0, b0;
    d0 = done_cnt; f0 = frames_seen; b0 = busy_falls;
    do_write(8'hA5);
    do_write(8'h3C);
    wait_idle("b2b");
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d, required 2", done_cnt - d0); end
    n_checks++; if (frames_seen - f0 != 2) begin n_fail++; $display("FAIL b2b_frames: got %0d, required 2", frames_seen - f0); end
    n_checks++; if (busy_falls - b0 != 1) begin n_fail++; $display("FAIL b2b_busy_periods: got %0d, required 1", busy_falls - b0); end
    n_checks++; if (last_gap != 0) begin n_fail++; $display("FAIL b2b_gap_clks: got %0d, required 0", last_gap); end
  endtask

  task automatic test_drop_when_full();
    int d0, f0;
    d0 = done_cnt; f0 = frames_seen;
    do_write(8'h11);
    do_write(8'h22);
    #1;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready_low: got %b, required 0", tx_ready); end
    data_in  = 8'h33;
    tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("drop");
    repeat (40) @(negedge clk);
    #1;
    n_checks++; if (frames_seen - f0 != 2) begin n_fail++; $display("FAIL drop_frames: got %0d, required 2", frames_seen - f0); end
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL drop_done_pulses: got %0d, required 2", done_cnt - d0); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_end: got %b, required 0", tx_busy); end
  endtask

  task automatic test_two_stop();
    logic [7:0] exp;
    logic       expb;
    int         w;
    int         nb;
    nb = 11 + PAR;
    @(negedge clk);
    #1;
    n_checks++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL stop2_ready: got %b, required 1", ready2); end
    @(negedge clk);
    data2  = 8'hFF;
    valid2 = 1'b1;
    q2.push_back(8'hFF);
    @(negedge clk);
    valid2 = 1'b0;
    w = 0;
    while ((serial2 !== 1'b0) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (serial2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop2_start_timeout: line=%b after %0d clks, required 0", serial2, w);
      return;
    end
    exp = q2.pop_front();
    for (int t = 0; t <= 16 * nb; t++) begin
      if (t > 0) @(negedge clk);
      if ((t % 16 == 8) && (t < 16 * nb)) begin
        expb = frame_bit(exp, t / 16, 1'b0);
        n_checks++;
        if (serial2 !== expb) begin
          n_fail++;
          $display("FAIL stop2_bit%0d: got %b, required %b", t / 16, serial2, expb);
        end
      end
      if (t == 16 * nb - 1) begin
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL stop2_done_early: got %b, required 0", done2); end
      end
      if (t == 16 * nb) begin
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL stop2_done: got %b, required 1", done2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL stop2_busy_end: got %b, required 0", busy2); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w, d0, f0;
    do_write(8'h0F);
    w = 0;
    while ((tx_serial !== 1'b0) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready_at_load: got %b, required 1", tx_ready);
    end
    data_in  = 8'hF0;
    tx_valid = 1'b1;
    q.push_back(8'hF0);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (71) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL midrst_serial: got %b, required 1", tx_serial); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", tx_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt; f0 = frames_seen;
    repeat (40) @(negedge clk);
    #1;
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_cleared: busy=%b, required 0", tx_busy); end
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses, required 0", done_cnt - d0); end
    do_write(8'h81);
    wait_idle("midrst");
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (frames_seen - f0 != 1) begin n_fail++; $display("FAIL midrst_clean_frame: got %0d, required 1", frames_seen - f0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w;
    logic expp;
    do_write(8'h07);
    wait_idle("parity_even");
    @(negedge clk);
    data3  = 8'h07;
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    w = 0;
    while ((serial3 !== 1'b0) && (w < 100)) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (serial3 !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_start_timeout: line=%b, required 0", serial3);
      return;
    end
    expp = 1'b0;
    for (int t = 1; t <= 176; t++) begin
      @(negedge clk);
      if (t == 152) begin
        n_checks++; if (serial3 !== expp) begin n_fail++; $display("FAIL odd_parity_bit: got %b, required %b", serial3, expp); end
      end
      if (t == 168) begin
        n_checks++; if (serial3 !== 1'b1) begin n_fail++; $display("FAIL odd_stop_bit: got %b, required 1", serial3); end
      end
      if (t == 176) begin
        n_checks++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL odd_done: got %b, required 1", done3); end
      end
    end
  endtask
`endif

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    data_in  = 8'h00;
    valid2   = 1'b0;
    data2    = 8'h00;
`ifdef UART_TX_PARITY_EN
    valid3   = 1'b0;
    data3    = 8'h00;
`endif
    test_reset();
    test_single_55();
    test_back_to_back();
    test_drop_when_full();
    test_two_stop();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises parallel bytes onto a UART line: 8N1 by default, LSB first, idle-high.
- TX-side counterpart of the team's UART receiver; shares the same external one-clock-wide `baud_tick` strobe (one pulse per bit period).
- One-entry holding register decouples the producer from the shifter, so frames can go back-to-back with no idle gap.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8; data_in[DATA_BITS-1:0] used, upper bits ignored.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_ODD, 0, parity sense (0 even, 1 odd); only meaningful with UART_TX_PARITY_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- baud_tick  input  1  single-clk pulse, one per bit period.
- data_in  input  8  byte to send.
- tx_valid  input  1  producer offers data_in.
- tx_ready  output  1  holding register empty; write accepted when tx_valid && tx_ready.
- tx_serial  output  1  serial line, registered.
- tx_busy  output  1  shifter state != IDLE.
- tx_done  output  1  one-clk pulse at end of last stop bit.

Behaviour:
- Reset (async, immediate):
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Holding register empty; state IDLE; bit_idx=0; stop_cnt=0.
  - Any partial frame is abandoned with no glitch low.
- Write handshake:
  - On a clk edge with tx_valid && tx_ready, data_in is captured into hold_reg and hold_full=1.
  - tx_ready = !hold_full, registered; it falls the cycle after the write.
  - tx_valid while tx_ready=0 is ignored; no overwrite.
- States: IDLE, START, DATA, STOP (PARITY added by the optional feature). All transitions occur only on clk edges where baud_tick=1, except reset.
- IDLE:
  - tx_serial=1.
  - On baud_tick && hold_full: shift_reg<=hold_reg, hold_full<=0, tx_serial<=0, go START.
  - Start-bit launch therefore aligns to a tick, so every bit lasts exactly one tick interval.
- START:
  - On tick: tx_serial<=shift_reg[0], bit_idx<=0, go DATA.
- DATA:
  - On tick with bit_idx==DATA_BITS-1: tx_serial<=1, stop_cnt<=0, go STOP.
  - On tick otherwise: shift_reg right by 1, tx_serial<=next bit, bit_idx++.
- STOP:
  - On tick with stop_cnt<STOP_BITS-1: stop_cnt++, line held 1.
  - On tick with stop_cnt==STOP_BITS-1: tx_done=1 for exactly that clk cycle, then:
    - hold_full: load as in IDLE and go START (tx_serial<=0, back-to-back, zero gap).
    - otherwise: go IDLE.
- Simultaneous load and write:
  - In a load cycle hold_full was 1, so tx_ready=0 and no write can coincide.
  - tx_ready rises the cycle after the load.
  - A write in the same cycle as a tick in IDLE with hold_full=0 is not sent on that tick; it waits for the next tick.
- Latency: accepted write to start-bit edge = 1 clk + up to 1 tick interval when IDLE. Frame length = 1+DATA_BITS+STOP_BITS tick intervals (+1 with parity).
- tx_busy=1 from the START entry until the IDLE re-entry; it stays 1 across back-to-back frames.
- baud_tick held high for multiple clks is out of spec; each high clk advances one bit.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - On the last data tick: tx_serial<=parity, go PARITY; on the next tick go STOP.
  - parity = XOR of the data bits, XOR PARITY_ODD.
  - Frame grows by one tick interval.
- Undefined: no PARITY state, no parity logic; PARITY_ODD ignored.

Test Plan:
- Tick every 16 clks. Write 0x55 -> tx_serial bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); each bit 16 clks; tx_done one pulse; tx_busy back to 0.
- Write 0xA5, then 0x3C as soon as tx_ready rises -> two contiguous frames, no idle bit between; single tx_busy high period; two tx_done pulses.
- Write 0x11, then 0x22, then 0x33 while tx_ready=0 -> 0x33 dropped; line carries 0x11 then 0x22 only.
- STOP_BITS=2, write 0xFF -> 0 start, 8 ones, then 2 tick intervals high before tx_done.
- Assert rst during bit 3 of 0x0F -> tx_serial=1 within the same cycle; tx_ready=1, tx_busy=0; a subsequent write of 0x81 sends a clean frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0, write 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; stop bit follows.
